// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared types, defaults and PID helper for the USB RX control path
package usb_rx_pkg;
    typedef enum logic [3:0] {
        IDLE, SYNC_WAIT, BYTE_WAIT, STORE, EOP_EDGE, ERR_WAIT_EOP, ERR_EOP_EDGE, ERR_IDLE
    } rx_state_t;
    localparam logic [7:0] SYNC_DEFAULT = 8'h80;
    function automatic logic pid_ok(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction
endpackage

// File: rtl/usb_rx_ctrl_flex_counter.sv
// flex_counter: clearable up-counter that saturates at LIMIT
module flex_counter #(
    parameter int WIDTH = 7,
    parameter logic [WIDTH-1:0] LIMIT = '1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) count <= '0;
        else if (clear) count <= '0;
        else if (count_enable && count != LIMIT) count <= count + 1'b1;
endmodule

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: USB RX control FSM (SYNC check, byte count, EOP/overflow errors); USB_RX_PID_CHECK_EN adds a first-byte PID check
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
    parameter int MAX_BYTES = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_edge,
    input  logic             eop,
    input  logic             shift_enable,
    input  logic             byte_received,
    input  logic [7:0]       rcv_data,
    output logic             rcving,
    output logic             w_enable,
    output logic [7:0]       rx_byte,
    output logic             r_error,
    output logic [CNT_W-1:0] byte_count
);
    rx_state_t state;
    logic [2:0] bit_cnt;
    logic full, pid_bad;
    assign full = byte_count == CNT_W'(MAX_BYTES);
`ifdef USB_RX_PID_CHECK_EN
    assign pid_bad = byte_count == '0 && !pid_ok(rcv_data);
`else
    assign pid_bad = 1'b0;
`endif
    assign rcving   = state != IDLE && state != ERR_IDLE;
    assign w_enable = state == STORE;
    assign r_error  = state == ERR_WAIT_EOP || state == ERR_EOP_EDGE || state == ERR_IDLE;
    flex_counter #(.WIDTH(CNT_W), .LIMIT(CNT_W'(MAX_BYTES))) u_byte_cnt (
        .clk(clk),
        .n_rst(n_rst),
        .clear(state == IDLE && d_edge),
        .count_enable(state == STORE),
        .count(byte_count)
    );
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) bit_cnt <= '0;
        else if (byte_received) bit_cnt <= '0;
        else if (shift_enable && rcving) bit_cnt <= bit_cnt + 1'b1;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            state   <= IDLE;
            rx_byte <= '0;
        end else begin
            case (state)
                IDLE:      if (d_edge) state <= SYNC_WAIT;
                SYNC_WAIT:
                    if (byte_received) state <= rcv_data == SYNC_BYTE ? BYTE_WAIT : ERR_WAIT_EOP;
                    else if (eop && shift_enable) state <= ERR_EOP_EDGE;
                BYTE_WAIT:
                    if (byte_received) begin
                        if (full || pid_bad) state <= ERR_WAIT_EOP;
                        else begin
                            state   <= STORE;
                            rx_byte <= rcv_data;
                        end
                    end else if (eop && shift_enable)
                        state <= bit_cnt == '0 ? EOP_EDGE : ERR_EOP_EDGE;
                STORE:        state <= BYTE_WAIT;
                EOP_EDGE:     if (d_edge) state <= IDLE;
                ERR_WAIT_EOP: if (eop && shift_enable) state <= ERR_EOP_EDGE;
                ERR_EOP_EDGE: if (d_edge) state <= ERR_IDLE;
                ERR_IDLE:     if (d_edge) state <= SYNC_WAIT;
                default:      state <= IDLE;
            endcase
        end
endmodule
